inst_intensity_gen: RTL

INST_INTENSITY_GEN -- requirements
Module: inst_intensity_gen

---
 rtl/inst_intensity_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/inst_intensity_gen.sv
// Per-instrument display intensity generator: latches drum hits as pending levels,
// then once per frame walks every channel through hold/decay and commits all levels at once.
//
// state     | meaning
// ST_WAIT   | idle, waiting for frame_tick
// ST_SCAN   | update one channel per cycle, index 0..INSTRUMENT_COUNT-1
// ST_COMMIT | copy all shadow levels to the outputs in one cycle

module inst_intensity_gen #(
  parameter int INSTRUMENT_COUNT = 3,
  parameter int HOLD_FRAMES      = 2,
  parameter int DECAY_SHIFT      = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                frame_tick,
  input  logic                                trig_valid,
  input  logic [$clog2(INSTRUMENT_COUNT)-1:0] trig_inst,
  input  logic [6:0]                          trig_velocity,
  output logic [7:0]                          inst_intensity [INSTRUMENT_COUNT],
  output logic                                busy,
  output logic                                overrun
);

  localparam int              IW       = $clog2(INSTRUMENT_COUNT);
  localparam logic [IW:0]     LP_COUNT = (IW+1)'(INSTRUMENT_COUNT);
  localparam logic [IW-1:0]   LP_LAST  = IW'(INSTRUMENT_COUNT - 1);
  localparam logic [3:0]      LP_HOLD  = 4'(HOLD_FRAMES);

  typedef enum logic [1:0] {ST_WAIT, ST_SCAN, ST_COMMIT} state_t;
  typedef enum logic [1:0] {CH_IDLE, CH_HOLD, CH_DECAY} ch_state_t;

  state_t                     r_state, w_state_nxt;
  logic [IW-1:0]              r_idx, w_idx_nxt;
  logic                       r_overrun;
  logic                       r_pend     [INSTRUMENT_COUNT];
  logic [7:0]                 r_pend_lvl [INSTRUMENT_COUNT];
  logic [7:0]                 r_shadow   [INSTRUMENT_COUNT];
  logic [3:0]                 r_hold     [INSTRUMENT_COUNT];
  ch_state_t                  r_ch       [INSTRUMENT_COUNT];
  logic [7:0]                 r_intensity[INSTRUMENT_COUNT];

  logic                       w_trig_ok;
  logic [7:0]                 w_trig_lvl;
  logic [INSTRUMENT_COUNT-1:0] w_proc, w_hit;
  logic [7:0]                 w_cur, w_diff, w_dec, w_shadow_nxt;
  logic [3:0]                 w_hold_nxt;
  ch_state_t                  w_ch_nxt;

  assign w_trig_lvl = {trig_velocity, trig_velocity[6]};
  assign w_trig_ok  = trig_valid && (trig_velocity != 7'd0) && ({1'b0, trig_inst} < LP_COUNT);
  assign overrun    = r_overrun;
  assign inst_intensity = r_intensity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WAIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    busy        = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (frame_tick) begin
          w_state_nxt = ST_SCAN;
          w_idx_nxt   = '0;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (r_idx == LP_LAST) begin
          w_state_nxt = ST_COMMIT;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      ST_COMMIT: begin
        busy        = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_overrun <= 1'b0;
    else if (frame_tick && busy) r_overrun <= 1'b1;
  end

  always_comb begin
    w_proc = '0;
    w_hit  = '0;
    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
      w_proc[i] = (r_state == ST_SCAN) && (r_idx == IW'(i));
      w_hit[i]  = w_trig_ok && (trig_inst == IW'(i));
    end
  end

  // Next channel values for the channel under scan; cur - cur>>S never underflows.
  always_comb begin
    w_cur        = r_shadow[r_idx];
    w_diff       = w_cur - (w_cur >> DECAY_SHIFT);
    w_dec        = (w_diff == 8'd0) ? 8'd0 : w_diff - 8'd1;
    w_shadow_nxt = w_cur;
    w_hold_nxt   = r_hold[r_idx];
    w_ch_nxt     = r_ch[r_idx];
    if (r_pend[r_idx]) begin
      w_shadow_nxt = r_pend_lvl[r_idx];
      w_hold_nxt   = LP_HOLD;
      w_ch_nxt     = (LP_HOLD == 4'd0) ? CH_DECAY : CH_HOLD;
    end else begin
      case (r_ch[r_idx])
        CH_HOLD: begin
          if (r_hold[r_idx] != 4'd0) begin
            w_hold_nxt = r_hold[r_idx] - 4'd1;
          end else begin
            w_shadow_nxt = w_dec;
            w_ch_nxt     = (w_dec == 8'd0) ? CH_IDLE : CH_DECAY;
          end
        end
        CH_DECAY: begin
          w_shadow_nxt = w_dec;
          w_ch_nxt     = (w_dec == 8'd0) ? CH_IDLE : CH_DECAY;
        end
        default: w_shadow_nxt = 8'd0;
      endcase
    end
  end

  // A hit on the channel being scanned stays pending with only its own level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        r_pend[i]     <= 1'b0;
        r_pend_lvl[i] <= '0;
        r_shadow[i]   <= '0;
        r_hold[i]     <= '0;
        r_ch[i]       <= CH_IDLE;
      end
    end else begin
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        if (w_proc[i]) begin
          r_shadow[i] <= w_shadow_nxt;
          r_hold[i]   <= w_hold_nxt;
          r_ch[i]     <= w_ch_nxt;
        end
        if (w_hit[i]) begin
          r_pend[i] <= 1'b1;
          if (w_proc[i] || !r_pend[i] || (w_trig_lvl > r_pend_lvl[i]))
            r_pend_lvl[i] <= w_trig_lvl;
        end else if (w_proc[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INSTRUMENT_COUNT; i++) r_intensity[i] <= '0;
    end else if (r_state == ST_COMMIT) begin
      for (int i = 0; i < INSTRUMENT_COUNT; i++) r_intensity[i] <= r_shadow[i];
    end
  end

endmodule
